// File: rtl/sdu_pkg.sv
// Shared types and command constants for the serial debug unit.
package sdu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_e;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_HALT  = 8'h48;
    localparam logic [7:0] CMD_STEP  = 8'h53;

endpackage

// File: rtl/sdu_cmd_loader_if.sv
// Memory-write request channel from the debug loader into the core memories.
interface sdu_cmd_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/sdu_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, glitch rejection on the start bit.
module sdu_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       err_frame_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rxd_s;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    assign rxd_s = sync_q[1];

    // Synchronizer resets to the idle-high level so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking here so every flop samples the values from before this edge.
            sync_q <= {sync_q[0], rxd_i};
            prev_q <= rxd_s;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rxd_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rxd_s;
                    err_d   = !rxd_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rx_valid_o  = valid_q;
    assign rx_byte_o   = shift_q;
    assign err_frame_o = err_q;

endmodule

// File: rtl/sdu_cmd_loader.sv
// Serial debug front end: decodes UART commands into core run/halt/step control and memory writes.
module sdu_cmd_loader
    import sdu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             uart_rxd,
    sdu_cmd_loader_if.master wr_if,
    output logic             cpu_run,
    output logic             cpu_step,
    output logic             busy,
    output logic             err_frame,
    output logic             err_overrun
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ADDR  = ADDR;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_WRITE = WRITE;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        run_q, run_d;
    logic        step_q, step_d;
    logic        ovr_q, ovr_d;

    sdu_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (cpu_clk),
        .rst         (cpu_rst),
        .rxd_i       (uart_rxd),
        .rx_valid_o  (rx_valid),
        .rx_byte_o   (rx_byte),
        .err_frame_o (rx_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        run_d   = run_q;
        step_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_byte)
                        CMD_WRITE: begin
                            run_d   = 1'b0;
                            cnt_d   = 2'd0;
                            state_d = ST_ADDR;
                        end
                        CMD_RUN:  run_d  = 1'b1;
                        CMD_HALT: run_d  = 1'b0;
                        CMD_STEP: step_d = !run_q;
                        default:  ;
                    endcase
                end
            end
            // Words arrive little-endian, so each byte enters at the top and shifts down.
            ST_ADDR: begin
                if (rx_err) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    addr_d = {rx_byte, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_err) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    data_d = {rx_byte, data_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ST_WRITE;
                end
            end
            default: begin
                // A framing error here is ignored: the assembled write is already committed.
                ovr_d = rx_valid;
                if (wr_if.wr_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            // NOTE: the assembly registers are reset because they drive wr_addr/wr_data directly.
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            run_q   <= 1'b0;
            step_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            run_q   <= run_d;
            step_q  <= step_d;
            ovr_q   <= ovr_d;
        end
    end

    assign wr_if.wr_valid = (state_q == ST_WRITE);
    assign wr_if.wr_addr  = addr_q[ADDR_WIDTH-1:0];
    assign wr_if.wr_data  = data_q[DATA_WIDTH-1:0];
    assign cpu_run        = run_q;
    assign cpu_step       = step_q;
    assign busy           = (state_q != ST_IDLE);
    assign err_frame      = rx_err;
    assign err_overrun    = ovr_q;

endmodule

// File: tb/tb_sdu_cmd_loader.sv
// Randomized self-checking bench for sdu_cmd_loader against a command-level reference model.
module tb_sdu_cmd_loader;
    localparam int CPB = 4;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    logic uart_rxd = 1'b1;
    logic cpu_run, cpu_step, busy, err_frame, err_overrun;

    sdu_cmd_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wr_if ();

    sdu_cmd_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CLKS_PER_BIT(CPB)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .uart_rxd    (uart_rxd),
        .wr_if       (wr_if),
        .cpu_run     (cpu_run),
        .cpu_step    (cpu_step),
        .busy        (busy),
        .err_frame   (err_frame),
        .err_overrun (err_overrun)
    );

    initial forever #5 cpu_clk = ~cpu_clk;

    int total = 0;
    int bad = 0;

    // Event counters observed mid-cycle, away from the rising edge.
    int vcyc = 0, hs_cnt = 0, step_cyc = 0, ferr_cnt = 0, ovr_cnt = 0, rxv_cnt = 0;
    logic [31:0] last_addr = 32'h0, last_data = 32'h0;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    always @(negedge cpu_clk) begin
        #1;
        if (!cpu_rst) begin
            if (wr_if.wr_valid) vcyc++;
            if (wr_if.wr_valid && wr_if.wr_ready) begin
                hs_cnt++;
                last_addr = wr_if.wr_addr;
                last_data = wr_if.wr_data;
                got_addr.push_back(wr_if.wr_addr);
                got_data.push_back(wr_if.wr_data);
            end
            if (cpu_step) step_cyc++;
            if (err_frame) ferr_cnt++;
            if (err_overrun) ovr_cnt++;
            if (dut.rx_valid) rxv_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        @(negedge cpu_clk);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            repeat (CPB) @(negedge cpu_clk);
        end
        uart_rxd = 1'b1;
        repeat (2 * CPB) @(negedge cpu_clk);
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({wr_if.wr_valid, cpu_run, cpu_step, busy, err_frame, err_overrun} !== 6'b0) begin
            bad++;
            $display("FAIL %s flags: got %b want 000000", tag,
                     {wr_if.wr_valid, cpu_run, cpu_step, busy, err_frame, err_overrun});
        end
        total++;
        if (wr_if.wr_addr !== 32'h0) begin
            bad++; $display("FAIL %s wr_addr: got %h want 0", tag, wr_if.wr_addr);
        end
        total++;
        if (wr_if.wr_data !== 32'h0) begin
            bad++; $display("FAIL %s wr_data: got %h want 0", tag, wr_if.wr_data);
        end
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        wr_if.wr_ready = 1'b1;
        repeat (3) @(negedge cpu_clk);
        check_reset_outputs("reset");
        cpu_rst = 1'b0;
        repeat (4) @(negedge cpu_clk);
    endtask

    task automatic test_write();
        int v0, h0;
        v0 = vcyc; h0 = hs_cnt;
        wr_if.wr_ready = 1'b1;
        send_write(32'h12345678, 32'hDEADBEEF);
        repeat (2) @(negedge cpu_clk);
        total++;
        if (vcyc - v0 != 1) begin bad++; $display("FAIL write valid_cycles: got %0d want 1", vcyc - v0); end
        total++;
        if (hs_cnt - h0 != 1) begin bad++; $display("FAIL write transfers: got %0d want 1", hs_cnt - h0); end
        total++;
        if (last_addr !== 32'h12345678) begin bad++; $display("FAIL write addr: got %h want 12345678", last_addr); end
        total++;
        if (last_data !== 32'hDEADBEEF) begin bad++; $display("FAIL write data: got %h want deadbeef", last_data); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL write busy_after: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        int h0, o0, waited, unstable;
        h0 = hs_cnt; o0 = ovr_cnt;
        wr_if.wr_ready = 1'b0;
        send_write(32'hCAFE0010, 32'h0BADF00D);
        waited = 0;
        while (wr_if.wr_valid !== 1'b1 && waited < 200) begin
            @(negedge cpu_clk); waited++;
        end
        total++;
        if (waited >= 200) begin bad++; $display("FAIL stall wr_valid_timeout: got 0 want 1"); end
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge cpu_clk);
            if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== 32'hCAFE0010 ||
                wr_if.wr_data !== 32'h0BADF00D) unstable++;
        end
        total++;
        if (unstable != 0) begin bad++; $display("FAIL stall hold: got %0d unstable cycles want 0", unstable); end
        send_byte(8'h52, 1'b1);
        repeat (2) @(negedge cpu_clk);
        total++;
        if (ovr_cnt - o0 != 1) begin bad++; $display("FAIL stall overrun: got %0d want 1", ovr_cnt - o0); end
        total++;
        if (cpu_run !== 1'b0) begin bad++; $display("FAIL stall run: got %b want 0", cpu_run); end
        total++;
        if (wr_if.wr_valid !== 1'b1 || hs_cnt != h0) begin
            bad++; $display("FAIL stall still_pending: got valid=%b xfers=%0d want 1/0", wr_if.wr_valid, hs_cnt - h0);
        end
        wr_if.wr_ready = 1'b1;
        repeat (4) @(negedge cpu_clk);
        total++;
        if (hs_cnt - h0 != 1) begin bad++; $display("FAIL stall transfers: got %0d want 1", hs_cnt - h0); end
        total++;
        if (last_addr !== 32'hCAFE0010 || last_data !== 32'h0BADF00D) begin
            bad++; $display("FAIL stall payload: got %h/%h want cafe0010/0badf00d", last_addr, last_data);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL stall busy_after: got %b want 0", busy); end
    endtask

    task automatic test_run_step();
        int s0;
        s0 = step_cyc;
        send_byte(8'h52, 1'b1);
        total++;
        if (cpu_run !== 1'b1) begin bad++; $display("FAIL runstep run_set: got %b want 1", cpu_run); end
        send_byte(8'h53, 1'b1);
        total++;
        if (step_cyc != s0) begin bad++; $display("FAIL runstep step_while_run: got %0d want 0", step_cyc - s0); end
        send_byte(8'h48, 1'b1);
        total++;
        if (cpu_run !== 1'b0) begin bad++; $display("FAIL runstep halt: got %b want 0", cpu_run); end
        send_byte(8'h53, 1'b1);
        total++;
        if (step_cyc - s0 != 1) begin bad++; $display("FAIL runstep step_cycles: got %0d want 1", step_cyc - s0); end
    endtask

    task automatic test_frame_err();
        int f0, h0, v0;
        f0 = ferr_cnt; h0 = hs_cnt; v0 = vcyc;
        send_byte(8'h57, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (2) @(negedge cpu_clk);
        total++;
        if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL frame err_pulses: got %0d want 1", ferr_cnt - f0); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL frame aborted: got busy=%b want 0", busy); end
        send_byte(8'h52, 1'b1);
        total++;
        if (cpu_run !== 1'b1) begin bad++; $display("FAIL frame run_after: got %b want 1", cpu_run); end
        total++;
        if (vcyc != v0 || hs_cnt != h0) begin bad++; $display("FAIL frame no_write: got %0d valid cycles want 0", vcyc - v0); end
        send_byte(8'h48, 1'b1);
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = rxv_cnt; f0 = ferr_cnt;
        @(negedge cpu_clk);
        uart_rxd = 1'b0;
        repeat (2) @(negedge cpu_clk);
        uart_rxd = 1'b1;
        repeat (20 * CPB) @(negedge cpu_clk);
        total++;
        if (rxv_cnt != r0) begin bad++; $display("FAIL glitch rx_valid: got %0d want 0", rxv_cnt - r0); end
        total++;
        if (ferr_cnt != f0) begin bad++; $display("FAIL glitch err_frame: got %0d want 0", ferr_cnt - f0); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL glitch busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int h0;
        send_byte(8'h57, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rstmid busy_before: got %b want 1", busy); end
        cpu_rst = 1'b1;
        repeat (2) @(negedge cpu_clk);
        check_reset_outputs("rstmid");
        cpu_rst = 1'b0;
        repeat (2) @(negedge cpu_clk);
        h0 = hs_cnt;
        send_write(32'h89ABCDEF, 32'h01234567);
        repeat (2) @(negedge cpu_clk);
        total++;
        if (hs_cnt - h0 != 1) begin bad++; $display("FAIL rstmid transfers: got %0d want 1", hs_cnt - h0); end
        total++;
        if (last_addr !== 32'h89ABCDEF || last_data !== 32'h01234567) begin
            bad++; $display("FAIL rstmid payload: got %h/%h want 89abcdef/01234567", last_addr, last_data);
        end
    endtask

    // Reference model: command-level semantics only (run flag, step count, list of writes).
    task automatic test_random();
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        bit          m_run;
        int          m_steps, s0, g0, k;
        logic [31:0] a, d;
        logic [7:0]  other;
        cpu_rst = 1'b1;
        repeat (2) @(negedge cpu_clk);
        cpu_rst = 1'b0;
        repeat (2) @(negedge cpu_clk);
        m_run = 1'b0; m_steps = 0;
        s0 = step_cyc; g0 = got_addr.size();
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: begin
                    a = $urandom; d = $urandom;
                    send_write(a, d);
                    exp_addr.push_back(a); exp_data.push_back(d);
                    m_run = 1'b0;
                end
                1: begin send_byte(8'h52, 1'b1); m_run = 1'b1; end
                2: begin send_byte(8'h48, 1'b1); m_run = 1'b0; end
                3: begin send_byte(8'h53, 1'b1); if (!m_run) m_steps++; end
                default: begin
                    do other = 8'($urandom);
                    while (other == 8'h57 || other == 8'h52 || other == 8'h48 || other == 8'h53);
                    send_byte(other, 1'b1);
                end
            endcase
            total++;
            if (cpu_run !== m_run) begin bad++; $display("FAIL random run[%0d]: got %b want %b", n, cpu_run, m_run); end
        end
        repeat (2) @(negedge cpu_clk);
        total++;
        if (step_cyc - s0 != m_steps) begin bad++; $display("FAIL random steps: got %0d want %0d", step_cyc - s0, m_steps); end
        total++;
        if (got_addr.size() - g0 != exp_addr.size()) begin
            bad++; $display("FAIL random writes: got %0d want %0d", got_addr.size() - g0, exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                total++;
                if (got_addr[g0+i] !== exp_addr[i] || got_data[g0+i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL random write[%0d]: got %h/%h want %h/%h", i,
                             got_addr[g0+i], got_data[g0+i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    initial begin
        wr_if.wr_ready = 1'b1;
        test_reset();
        test_write();
        test_stall();
        test_run_step();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
